// File: rtl/switchbox_config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switchbox_config_pkg
// Description : Shared types, defaults and helpers for the switch box
//               configuration loader. The readback state exists only when
//               SWITCHBOX_CONFIG_LOADER_READBACK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package switchbox_config_pkg;

    localparam int DEF_CONFIG_WIDTH = 384;
    localparam int DEF_WORD_WIDTH   = 32;

    // Loader state encoding
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE     = 2'd0;
    localparam state_t S_LOAD     = 2'd1;
    localparam state_t S_CHECK    = 2'd2;
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
    localparam state_t S_READBACK = 2'd3;
`endif

    // Data words per frame: enough words to cover every config bit
    function automatic int calc_num_words(input int config_width, input int word_width);
        return (config_width + word_width - 1) / word_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/switchbox_config_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : switchbox_config_loader_if
// Description : Configuration stream from the tile distributor to a loader:
//               frame start pulse plus a valid/ready word channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface switchbox_config_loader_if
    import switchbox_config_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
);
    logic                  load_start;
    logic [WORD_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;

    modport master (output load_start, output data_in, output data_valid, input  data_ready);
    modport slave  (input  load_start, input  data_in, input  data_valid, output data_ready);
endinterface
`default_nettype wire

// File: rtl/switchbox_config_loader_word_counter.sv
`default_nettype none
// ============================================================================
// Module      : config_word_counter
// Description : Loadable, clearable up-counter with terminal-count flag.
//               Clear has priority over load, load over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module config_word_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 12
) (
    input  wire              clock,
    input  wire              reset,
    input  wire              clear,
    input  wire              load,
    input  wire  [WIDTH-1:0] load_value,
    input  wire              inc,
    output logic [WIDTH-1:0] count,
    output logic             tc
);
    logic [WIDTH-1:0] r_count;

    // Counter register with clear/load/increment priority
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign tc    = (r_count == WIDTH'(TERMINAL));
endmodule
`default_nettype wire

// File: rtl/switchbox_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : switchbox_config_loader
// Description : Assembles a switch box configuration frame from a word
//               stream into a shadow register, verifies the trailing XOR
//               checksum word and commits the frame atomically to config_out.
//               Optional readback streams config_out back out when
//               SWITCHBOX_CONFIG_LOADER_READBACK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module switchbox_config_loader
    import switchbox_config_pkg::*;
#(
    parameter int CONFIG_WIDTH = DEF_CONFIG_WIDTH,
    parameter int WORD_WIDTH   = DEF_WORD_WIDTH
) (
    input  wire                     clock,
    input  wire                     reset,
    switchbox_config_loader_if.slave cfg_if,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    busy,
    output logic                    done,
    output logic                    error
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
    ,
    input  wire                     rb_start,
    output logic [WORD_WIDTH-1:0]   rb_data,
    output logic                    rb_valid,
    input  wire                     rb_ready
`endif
);
    localparam int NUM_WORDS = calc_num_words(CONFIG_WIDTH, WORD_WIDTH);
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);

    state_t                  r_state;
    logic [CONFIG_WIDTH-1:0] r_shadow;
    logic [CONFIG_WIDTH-1:0] r_config;
    logic [WORD_WIDTH-1:0]   r_csum;
    logic [WORD_WIDTH-1:0]   r_csum_word;
    logic                    r_done;
    logic                    r_error;

    logic [CNT_W-1:0]        w_count;
    logic                    w_tc;
    logic                    w_start_load;
    logic                    w_word_acc;
    logic                    w_rb_begin;
    logic                    w_rb_acc;

    // load_start is honoured only in IDLE and LOAD; it wins over a same-cycle word
    assign w_start_load = cfg_if.load_start && ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign w_word_acc   = (r_state == S_LOAD) && !cfg_if.load_start && cfg_if.data_valid;

`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
    localparam int PAD_W = NUM_WORDS * WORD_WIDTH;
    logic [PAD_W-1:0] w_cfg_pad;
    logic [CNT_W-1:0] w_rb_idx;

    assign w_rb_begin = rb_start && (r_state == S_IDLE) && !cfg_if.load_start;
    assign rb_valid   = (r_state == S_READBACK) && !w_tc;
    assign w_rb_acc   = rb_valid && rb_ready;
    // Zero-extension makes unused bits of the last word read back as 0
    assign w_cfg_pad  = PAD_W'(r_config);
    assign w_rb_idx   = w_tc ? '0 : w_count;
    assign rb_data    = w_cfg_pad[w_rb_idx*WORD_WIDTH +: WORD_WIDTH];
`else
    assign w_rb_begin = 1'b0;
    assign w_rb_acc   = 1'b0;
`endif

    // Shared word index: data words during LOAD, output words during readback
    config_word_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (NUM_WORDS)
    ) u_word_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (w_start_load || w_rb_begin),
        .load       (1'b0),
        .load_value ('0),
        .inc        ((w_word_acc && !w_tc) || w_rb_acc),
        .count      (w_count),
        .tc         (w_tc)
    );

    // Control FSM, checksum accumulation and atomic commit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_config    <= '0;
            r_csum      <= '0;
            r_csum_word <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_load) begin
                        r_state <= S_LOAD;
                        r_csum  <= '0;
                        r_error <= 1'b0;
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
                    end else if (w_rb_begin) begin
                        r_state <= S_READBACK;
`endif
                    end
                end
                S_LOAD: begin
                    if (w_start_load) begin
                        r_csum  <= '0;
                        r_error <= 1'b0;
                    end else if (w_word_acc) begin
                        if (w_tc) begin
                            r_csum_word <= cfg_if.data_in;
                            r_state     <= S_CHECK;
                        end else begin
                            r_csum <= r_csum ^ cfg_if.data_in;
                        end
                    end
                end
                S_CHECK: begin
                    if (r_csum == r_csum_word) begin
                        r_config <= r_shadow;
                        r_done   <= 1'b1;
                    end else begin
                        r_error  <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
                S_READBACK: begin
                    if (w_tc) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Shadow assembly: word k lands at bits [k*WORD_WIDTH +: WORD_WIDTH];
    // bits of a partial last word beyond CONFIG_WIDTH are simply not stored
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (w_word_acc && !w_tc) begin
            for (int b = 0; b < CONFIG_WIDTH; b++) begin
                if ((b / WORD_WIDTH) == int'(w_count)) begin
                    r_shadow[b] <= cfg_if.data_in[b % WORD_WIDTH];
                end
            end
        end
    end

    assign cfg_if.data_ready = (r_state == S_LOAD);
    assign config_out        = r_config;
    assign done              = r_done;
    assign error             = r_error;
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
    assign busy = (r_state == S_LOAD) || (r_state == S_CHECK) || (r_state == S_READBACK);
`else
    assign busy = (r_state == S_LOAD) || (r_state == S_CHECK);
`endif
endmodule
`default_nettype wire

// File: tb/tb_switchbox_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_switchbox_config_loader
// Description : Directed/random bench for switchbox_config_loader with a
//               frame-level reference model (word array, XOR checksum,
//               committed-config image). Covers readback when
//               SWITCHBOX_CONFIG_LOADER_READBACK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switchbox_config_loader;
    localparam int CW = 384;
    localparam int WW = 32;
    localparam int NW = 12;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    switchbox_config_loader_if #(.WORD_WIDTH(WW)) bus ();

    logic [CW-1:0] config_out;
    logic          busy;
    logic          done;
    logic          error;
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
    logic          rb_start;
    logic [WW-1:0] rb_data;
    logic          rb_valid;
    logic          rb_ready;
`endif

    switchbox_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_if     (bus.slave),
        .config_out (config_out),
        .busy       (busy),
        .done       (done),
        .error      (error)
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
        ,
        .rb_start   (rb_start),
        .rb_data    (rb_data),
        .rb_valid   (rb_valid),
        .rb_ready   (rb_ready)
`endif
    );

    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] model_cfg;
    logic [WW-1:0] words [NW];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cfg(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference checksum: XOR of all data words of the frame
    function automatic logic [WW-1:0] frame_xor();
        logic [WW-1:0] x = '0;
        for (int i = 0; i < NW; i++) x ^= words[i];
        return x;
    endfunction

    // Reference config image: word i occupies bits [i*WW +: WW]
    function automatic logic [CW-1:0] frame_image();
        logic [CW-1:0] p = '0;
        for (int i = 0; i < NW; i++) p[i*WW +: WW] = words[i];
        return p;
    endfunction

    // Called at a falling edge; pulses load_start for one cycle
    task automatic start_now();
        bus.load_start = 1'b1;
        @(negedge clock);
        bus.load_start = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] w, input bit gaps, input bit chk_ready);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.data_valid = 1'b0;
                bus.data_in    = $urandom;
                @(negedge clock);
            end
        end
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        if (chk_ready) check_bit("ready_in_load", bus.data_ready, 1'b1);
        @(negedge clock);
        bus.data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [WW-1:0] csum, input bit gaps, input bit chk_ready);
        for (int i = 0; i < NW; i++) send_word(words[i], gaps, chk_ready);
        send_word(csum, gaps, chk_ready);
    endtask

    // Entered in the CHECK cycle; returns at the falling edge of the done cycle
    task automatic finish(input bit ok);
        check_bit("ready_in_check", bus.data_ready, 1'b0);
        check_bit("busy_in_check", busy, 1'b1);
        check_bit("done_early", done, 1'b0);
        @(negedge clock);
        if (ok) model_cfg = frame_image();
        check_bit("done_pulse", done, ok);
        check_bit("error_flag", error, !ok);
        check_cfg("config_out", config_out, model_cfg);
        check_bit("busy_after", busy, 1'b0);
    endtask

    initial begin
        begin : watchdog
            fork
                begin
                    #2_000_000;
                    $display("FAIL watchdog expired");
                    $fatal(1, "timeout");
                end
            join_none
        end
    end

    initial begin
        reset          = 1'b1;
        bus.load_start = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        model_cfg      = '0;
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
        rb_start = 1'b0;
        rb_ready = 1'b0;
`endif
        repeat (3) @(negedge clock);
        check_cfg("rst_config", config_out, '0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_error", error, 1'b0);
        check_bit("rst_ready", bus.data_ready, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Nominal one-hot-per-word frame with a fixed checksum
        for (int i = 0; i < NW; i++) words[i] = 32'h1 << i;
        start_now();
        send_frame(32'h0000_0FFF, 1'b0, 1'b0);
        finish(1'b1);
        @(negedge clock);
        check_bit("done_one_cycle", done, 1'b0);

        // Bad checksum: error set, config held, error sticky until next start
        start_now();
        send_frame(32'h0, 1'b0, 1'b0);
        finish(1'b0);
        @(negedge clock);
        check_bit("error_sticky", error, 1'b1);
        check_bit("no_done_bad", done, 1'b0);
        start_now();
        check_bit("error_cleared", error, 1'b0);

        // Gapped frame of identical words, even count -> checksum zero
        for (int i = 0; i < NW; i++) words[i] = 32'hA5A5_A5A5;
        send_frame(32'h0, 1'b1, 1'b1);
        finish(1'b1);

        // Start on the done cycle, abort after 5 words with a word in the abort cycle
        start_now();
        check_bit("start_on_done", busy, 1'b1);
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0, 1'b0);
        bus.load_start = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = $urandom;
        @(negedge clock);
        bus.load_start = 1'b0;
        bus.data_valid = 1'b0;
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        send_frame(frame_xor(), 1'b0, 1'b0);
        finish(1'b1);
        @(negedge clock);

        // load_start held during CHECK must not start a new frame
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        start_now();
        send_frame(frame_xor(), 1'b1, 1'b0);
        bus.load_start = 1'b1;
        finish(1'b1);
        bus.load_start = 1'b0;
        @(negedge clock);
        check_bit("start_in_check_ignored", busy, 1'b0);

        // Random frames, some with a single corrupted checksum bit
        for (int f = 0; f < 4; f++) begin
            bit good;
            logic [WW-1:0] cs;
            good = 1'($urandom_range(0, 1));
            for (int i = 0; i < NW; i++) words[i] = $urandom;
            cs = frame_xor();
            if (!good) cs ^= (32'h1 << $urandom_range(0, 31));
            start_now();
            send_frame(cs, 1'b1, 1'b0);
            finish(good);
            @(negedge clock);
        end

        // Commit a known frame so later checks have a nonzero baseline
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        start_now();
        send_frame(frame_xor(), 1'b0, 1'b0);
        finish(1'b1);
        @(negedge clock);

`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
        begin : readback
            logic [WW-1:0] rbq[$];
            rb_start = 1'b1;
            @(negedge clock);
            rb_start = 1'b0;
            check_bit("rb_busy", busy, 1'b1);
            for (int c = 0; c < 200 && rbq.size() < NW; c++) begin
                rb_ready = (c % 2) == 1;
                if (rb_valid && rb_ready) rbq.push_back(rb_data);
                @(negedge clock);
            end
            rb_ready = 1'b0;
            check_word("rb_count", 32'(rbq.size()), 32'(NW));
            check_bit("rb_valid_end", rb_valid, 1'b0);
            for (int i = 0; i < NW; i++) begin
                if (i < rbq.size()) check_word("rb_data", rbq[i], words[i]);
            end
            @(negedge clock);
            check_bit("rb_idle", busy, 1'b0);
        end
`endif

        // Reset seven words into a frame: committed config is wiped too
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        start_now();
        for (int i = 0; i < 7; i++) send_word(words[i], 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_cfg = '0;
        check_cfg("midrst_config", config_out, model_cfg);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_ready", bus.data_ready, 1'b0);
        check_bit("midrst_done", done, 1'b0);
        @(negedge clock);
        check_bit("midrst_stays_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
